bp_dma_mem_responder: RTL and testbench
=======================================

BP_DMA_MEM_RESPONDER -- requirements
Module: bp_dma_mem_responder

Interface
REQ-001 Parameter daddr_width_p, default 28, DMA byte-address width.
REQ-002 Parameter data_width_p, default 64, width of one DMA data beat (l2_fill_width_p).
REQ-003 Parameter block_beats_p, default 8, beats per DMA block (power of 2).
REQ-004 Parameter mem_els_p, default 1024, storage depth in beats (power of 2, multiple of block_beats_p).
REQ-005 Parameter read_latency_p, default 4, cycles from packet accept to first read beat valid (>=1).
REQ-006 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset_i  input  1  synchronous, active-high reset.
REQ-008 dma_pkt_i  input  daddr_width_p+1  request: bit [daddr_width_p] = write_not_read, bits [daddr_width_p-1:0] = byte address.
REQ-009 dma_pkt_v_i  input  1  request valid.
REQ-010 dma_pkt_ready_and_o  output  1  request accepted when high with dma_pkt_v_i.
REQ-011 dma_data_i  input  data_width_p  write beat from the cache.
REQ-012 dma_data_v_i  input  1  write beat valid.
REQ-013 dma_data_ready_and_o  output  1  write beat accepted when high with dma_data_v_i.
REQ-014 dma_data_o  output  data_width_p  read beat to the cache.
REQ-015 dma_data_v_o  output  1  read beat valid.
REQ-016 dma_data_ready_and_i  input  1  read beat consumed when high with dma_data_v_o.

Function
REQ-017 Storage SHALL be mem_els_p x data_width_p, organised as mem_els_p/block_beats_p blocks.
REQ-018 Block index SHALL be (addr / (block_beats_p*data_width_p/8)) mod (mem_els_p/block_beats_p); low address bits ignored, beats always start at beat 0 of the block.
REQ-019 FSM states SHALL be IDLE, RD_WAIT, RD_SEND, WR_RECV.
REQ-020 dma_pkt_ready_and_o SHALL be 1 only in IDLE; one packet outstanding at a time.
REQ-021 IDLE, read accepted -> RD_WAIT, latency counter loaded with read_latency_p-1, beat counter cleared.
REQ-022 RD_WAIT SHALL decrement the counter each cycle and enter RD_SEND when it is 0; first dma_data_v_o thus asserts exactly read_latency_p cycles after the accept edge.
REQ-023 RD_SEND SHALL hold dma_data_v_o=1 and dma_data_o=mem[block][beat] stable until handshake; beat increments per handshake; handshake on beat block_beats_p-1 -> IDLE.
REQ-024 IDLE, write accepted -> WR_RECV, beat counter cleared.
REQ-025 WR_RECV SHALL assert dma_data_ready_and_o=1 and write dma_data_i to mem[block][beat] on each handshake; handshake on last beat -> IDLE.
REQ-026 dma_data_ready_and_o SHALL be 0 outside WR_RECV; write beats arriving before the write packet is accepted SHALL be held off, not dropped.
REQ-027 dma_data_v_o SHALL be 0 outside RD_SEND.
REQ-028 Read of a block written by an earlier completed write SHALL return the written data; a new packet is accepted no earlier than the cycle after the last beat handshake of the previous one.
REQ-029 Beat counter width SHALL be log2(block_beats_p); it SHALL not wrap within a transaction.
REQ-030 Backpressure (dma_data_ready_and_i=0 / dma_data_v_i=0) of any length SHALL stall without loss, duplication, or reordering of beats.

Reset
REQ-031 During reset_i=1: state=IDLE, counters=0, dma_pkt_ready_and_o=0, dma_data_v_o=0, dma_data_ready_and_o=0.
REQ-032 First cycle after reset deasserts: dma_pkt_ready_and_o=1.
REQ-033 Reset mid-transaction SHALL abort it; partial write beats already stored remain; no further beats of the aborted transaction are driven or accepted.
REQ-034 Storage contents SHALL not be cleared by reset.

Verification
REQ-035 Write pkt addr 0x40, beats 0x11..0x88 -> 8 ready handshakes, back to IDLE; read pkt 0x40 -> dma_data_v_o first high 4 cycles after accept, beats 0x11..0x88 in order.
REQ-036 Read addr 0x7F after REQ-035 -> same data as 0x40 (low bits ignored); addr 0x10040 -> aliases block 1 (mod 128 blocks), same data.
REQ-037 Read with dma_data_ready_and_i toggling 1,0,0,1 pattern -> exactly 8 handshakes, each beat held stable while stalled, no duplicates.
REQ-038 Write data driven valid 3 cycles before write pkt -> dma_data_ready_and_o=0 until pkt accepted, then all 8 beats stored correctly.
REQ-039 Reset asserted after 3rd read beat -> next cycle all outputs 0; after release new read returns full 8 beats from beat 0.
REQ-040 Second pkt held valid during RD_SEND -> not accepted until the cycle after the 8th beat handshake.

Source files
------------

// File: rtl/bp_dma_mem_responder.sv
// Block-oriented DMA memory model: accepts one read or write packet at a time and
// streams a whole block of beats from/to internal storage with valid/ready handshakes.
module bp_dma_mem_responder #(
    parameter int unsigned daddr_width_p  = 28,
    parameter int unsigned data_width_p   = 64,
    parameter int unsigned block_beats_p  = 8,
    parameter int unsigned mem_els_p      = 1024,
    parameter int unsigned read_latency_p = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic [daddr_width_p:0]   dma_pkt_i,
    input  logic                     dma_pkt_v_i,
    output logic                     dma_pkt_ready_and_o,

    input  logic [data_width_p-1:0]  dma_data_i,
    input  logic                     dma_data_v_i,
    output logic                     dma_data_ready_and_o,

    output logic [data_width_p-1:0]  dma_data_o,
    output logic                     dma_data_v_o,
    input  logic                     dma_data_ready_and_i
);

    localparam int unsigned BeatW  = $clog2(block_beats_p);
    localparam int unsigned Blocks = mem_els_p / block_beats_p;
    localparam int unsigned BlkW   = $clog2(Blocks);
    localparam int unsigned OffW   = $clog2(block_beats_p * data_width_p / 8);
    localparam int unsigned LatW   = (read_latency_p > 1) ? $clog2(read_latency_p) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRdWait,
        StRdSend,
        StWrRecv
    } state_e;

    state_e                  state_q, state_d;
    logic [LatW-1:0]         lat_q, lat_d;
    logic [BeatW-1:0]        beat_q, beat_d;
    logic [BlkW-1:0]         blk_q, blk_d;
    logic                    last_beat;
    logic                    mem_we;
    logic [BlkW+BeatW-1:0]   mem_idx;

    logic [data_width_p-1:0] mem_q [mem_els_p];

    // Byte offset within a block and address bits above the block index are don't-care.
    logic unused_pkt_bits;
    assign unused_pkt_bits = ^dma_pkt_i;

    assign mem_idx    = {blk_q, beat_q};
    assign last_beat  = (beat_q == BeatW'(block_beats_p - 1));
    assign dma_data_o = mem_q[mem_idx];

    always_comb begin
        state_d              = state_q;
        lat_d                = lat_q;
        beat_d               = beat_q;
        blk_d                = blk_q;
        dma_pkt_ready_and_o  = 1'b0;
        dma_data_ready_and_o = 1'b0;
        dma_data_v_o         = 1'b0;
        mem_we               = 1'b0;

        unique case (state_q)
            StIdle: begin
                dma_pkt_ready_and_o = 1'b1;
                if (dma_pkt_v_i) begin
                    blk_d  = dma_pkt_i[OffW +: BlkW];
                    beat_d = '0;
                    if (dma_pkt_i[daddr_width_p]) begin
                        state_d = StWrRecv;
                    end else begin
                        state_d = StRdWait;
                        lat_d   = LatW'(read_latency_p - 1);
                    end
                end
            end
            StRdWait: begin
                if (lat_q == '0) begin
                    state_d = StRdSend;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            StRdSend: begin
                dma_data_v_o = 1'b1;
                if (dma_data_ready_and_i) begin
                    beat_d = last_beat ? '0 : beat_q + 1'b1;
                    if (last_beat) begin
                        state_d = StIdle;
                    end
                end
            end
            StWrRecv: begin
                dma_data_ready_and_o = 1'b1;
                if (dma_data_v_i) begin
                    mem_we = 1'b1;
                    beat_d = last_beat ? '0 : beat_q + 1'b1;
                    if (last_beat) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Handshake outputs are forced low for the whole reset cycle, not just after it.
        if (reset_i) begin
            dma_pkt_ready_and_o  = 1'b0;
            dma_data_ready_and_o = 1'b0;
            dma_data_v_o         = 1'b0;
            mem_we               = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            lat_q   <= '0;
            beat_q  <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            blk_q   <= blk_d;
        end
    end

    // Storage is deliberately left untouched by reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_idx] <= dma_data_i;
        end
    end

endmodule

// File: tb/tb_bp_dma_mem_responder.sv
// Randomised bench for bp_dma_mem_responder: block-level memory model feeds an
// expected-beat queue that a free-running monitor drains on each read handshake.
module tb_bp_dma_mem_responder;

    localparam int unsigned AW          = 28;
    localparam int unsigned DW          = 64;
    localparam int unsigned BB          = 8;
    localparam int unsigned ME          = 1024;
    localparam int unsigned RL          = 4;
    localparam int unsigned BLOCK_BYTES = BB * DW / 8;
    localparam int unsigned NBLK        = ME / BB;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [AW:0]   dma_pkt_i;
    logic          dma_pkt_v_i;
    logic          dma_pkt_ready_and_o;
    logic [DW-1:0] dma_data_i;
    logic          dma_data_v_i;
    logic          dma_data_ready_and_o;
    logic [DW-1:0] dma_data_o;
    logic          dma_data_v_o;
    logic          dma_data_ready_and_i;

    always #5 clk = ~clk;

    bp_dma_mem_responder #(
        .daddr_width_p (AW),
        .data_width_p  (DW),
        .block_beats_p (BB),
        .mem_els_p     (ME),
        .read_latency_p(RL)
    ) dut (
        .clk_i               (clk),
        .reset_i             (reset_i),
        .dma_pkt_i           (dma_pkt_i),
        .dma_pkt_v_i         (dma_pkt_v_i),
        .dma_pkt_ready_and_o (dma_pkt_ready_and_o),
        .dma_data_i          (dma_data_i),
        .dma_data_v_i        (dma_data_v_i),
        .dma_data_ready_and_o(dma_data_ready_and_o),
        .dma_data_o          (dma_data_o),
        .dma_data_v_o        (dma_data_v_o),
        .dma_data_ready_and_i(dma_data_ready_and_i)
    );

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] model_mem [NBLK][BB];
    bit            known [NBLK];
    logic [DW-1:0] wbuf [BB];
    int            rd_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
    int            wr_gap_max = 0;

    logic          mon_pv = 1'b0;
    logic          mon_phs = 1'b0;
    logic [DW-1:0] mon_pd = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic int blk_of(input logic [AW-1:0] a);
        int unsigned ua;
        ua = 32'(a);
        return int'((ua / BLOCK_BYTES) % NBLK);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read-side consumer readiness, independent of the stimulus thread.
    initial begin
        int ph;
        ph = 0;
        dma_data_ready_and_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rd_mode)
                1:       dma_data_ready_and_i = ((ph % 4) == 0) || ((ph % 4) == 3);
                2:       dma_data_ready_and_i = 1'($urandom_range(0, 1));
                default: dma_data_ready_and_i = 1'b1;
            endcase
            ph++;
        end
    end

    // Monitor: checks stall stability and pops the scoreboard on each read handshake.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset_i && mon_pv && !mon_phs) begin
                check("rd_hold_valid", 64'(dma_data_v_o), 64'd1);
                if (dma_data_v_o) check("rd_hold_data", dma_data_o, mon_pd);
            end
            if (dma_data_v_o && dma_data_ready_and_i) begin
                if (exp_q.size() == 0) begin
                    fail_now("rd_unexpected_beat");
                end else begin
                    e = exp_q.pop_front();
                    check("rd_beat", dma_data_o, e);
                end
            end
            mon_pv  = dma_data_v_o && !reset_i;
            mon_phs = dma_data_v_o && dma_data_ready_and_i;
            mon_pd  = dma_data_o;
        end
    end

    task automatic send_pkt(input logic wr, input logic [AW-1:0] addr, output bit ok);
        logic rdy;
        ok          = 1'b0;
        dma_pkt_i   = {wr, addr};
        dma_pkt_v_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rdy = dma_pkt_ready_and_o;
            if (dma_data_v_i) check("wr_held_off", 64'(dma_data_ready_and_o), 64'd0);
            tick();
            if (rdy) begin
                ok = 1'b1;
                break;
            end
        end
        dma_pkt_v_i = 1'b0;
        if (!ok) fail_now("pkt_accept_timeout");
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input int pre);
        bit   ok;
        logic rdy;
        int   blk;
        blk = blk_of(addr);
        if (pre > 0) begin
            dma_data_i   = wbuf[0];
            dma_data_v_i = 1'b1;
            repeat (pre) begin
                @(negedge clk);
                check("wr_held_off_pre", 64'(dma_data_ready_and_o), 64'd0);
                tick();
            end
        end
        send_pkt(1'b1, addr, ok);
        if (!ok) begin
            dma_data_v_i = 1'b0;
            return;
        end
        for (int b = 0; b < int'(BB); b++) begin
            if (!(pre > 0 && b == 0)) begin
                dma_data_v_i = 1'b0;
                repeat ($urandom_range(0, wr_gap_max)) tick();
                dma_data_i   = wbuf[b];
                dma_data_v_i = 1'b1;
            end
            ok = 1'b0;
            for (int t = 0; t < 100; t++) begin
                @(negedge clk);
                rdy = dma_data_ready_and_o;
                tick();
                if (rdy) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                fail_now("wr_beat_timeout");
                dma_data_v_i = 1'b0;
                return;
            end
        end
        dma_data_v_i = 1'b0;
        for (int b = 0; b < int'(BB); b++) model_mem[blk][b] = wbuf[b];
        known[blk] = 1'b1;
        @(negedge clk);
        check("wr_done_pkt_ready", 64'(dma_pkt_ready_and_o), 64'd1);
        check("wr_done_data_ready", 64'(dma_data_ready_and_o), 64'd0);
        tick();
    endtask

    task automatic push_block(input logic [AW-1:0] addr);
        int blk;
        blk = blk_of(addr);
        for (int b = 0; b < int'(BB); b++) exp_q.push_back(model_mem[blk][b]);
    endtask

    // Called right after a read packet's accept edge: latency, drain, return to idle.
    task automatic finish_read();
        int lat;
        bit ok;
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dma_data_v_o) break;
            lat++;
        end
        check("rd_latency", 64'(lat), 64'(RL));
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (!ok) begin
            fail_now("rd_drain_timeout");
            exp_q.delete();
        end
        @(negedge clk);
        check("rd_done_pkt_ready", 64'(dma_pkt_ready_and_o), 64'd1);
        check("rd_done_valid", 64'(dma_data_v_o), 64'd0);
        tick();
    endtask

    task automatic do_read(input logic [AW-1:0] addr);
        bit ok;
        push_block(addr);
        send_pkt(1'b0, addr, ok);
        if (!ok) begin
            exp_q.delete();
            return;
        end
        finish_read();
    endtask

    // Second packet held valid during the first read's beats.
    task automatic read_hold(input logic [AW-1:0] addr1, input logic [AW-1:0] addr2);
        bit ok;
        bit acc;
        int done;
        logic rdy;
        logic hs;
        push_block(addr1);
        send_pkt(1'b0, addr1, ok);
        if (!ok) begin
            exp_q.delete();
            return;
        end
        dma_pkt_i   = {1'b0, addr2};
        dma_pkt_v_i = 1'b1;
        done = 0;
        acc  = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            rdy = dma_pkt_ready_and_o;
            hs  = dma_data_v_o && dma_data_ready_and_i;
            if (rdy) begin
                check("pkt2_accept_beats_done", 64'(done), 64'(BB));
                push_block(addr2);
                acc = 1'b1;
            end else if (done == int'(BB)) begin
                fail_now("pkt2_accept_late");
                break;
            end
            if (hs) done++;
            tick();
            if (acc) break;
        end
        dma_pkt_v_i = 1'b0;
        if (!acc) begin
            if (done != int'(BB)) fail_now("pkt2_never_accepted");
            exp_q.delete();
            return;
        end
        finish_read();
    endtask

    task automatic reset_mid_read(input logic [AW-1:0] addr);
        bit ok;
        int done;
        push_block(addr);
        send_pkt(1'b0, addr, ok);
        if (!ok) begin
            exp_q.delete();
            return;
        end
        done = 0;
        for (int t = 0; t < 300 && done < 3; t++) begin
            @(negedge clk);
            if (dma_data_v_o && dma_data_ready_and_i) done++;
            tick();
        end
        check("abort_beats_before_reset", 64'(done), 64'd3);
        reset_i = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("abort_pkt_ready", 64'(dma_pkt_ready_and_o), 64'd0);
        check("abort_data_v", 64'(dma_data_v_o), 64'd0);
        check("abort_data_ready", 64'(dma_data_ready_and_o), 64'd0);
        tick();
        tick();
        reset_i = 1'b0;
        @(negedge clk);
        check("abort_release_pkt_ready", 64'(dma_pkt_ready_and_o), 64'd1);
        tick();
        do_read(addr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [AW-1:0] wa;
        int            k;
        reset_i      = 1'b1;
        dma_pkt_i    = '0;
        dma_pkt_v_i  = 1'b0;
        dma_data_i   = '0;
        dma_data_v_i = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_pkt_ready", 64'(dma_pkt_ready_and_o), 64'd0);
        check("reset_data_v", 64'(dma_data_v_o), 64'd0);
        check("reset_data_ready", 64'(dma_data_ready_and_o), 64'd0);
        tick();
        reset_i = 1'b0;
        @(negedge clk);
        check("post_reset_pkt_ready", 64'(dma_pkt_ready_and_o), 64'd1);
        tick();

        for (int i = 0; i < int'(BB); i++) wbuf[i] = 64'h11 * 64'(i + 1);
        do_write(28'h40, 0);
        do_read(28'h40);
        do_read(28'h7F);
        do_read(28'h10040);

        rd_mode = 1;
        do_read(28'h40);
        rd_mode = 0;

        for (int i = 0; i < int'(BB); i++) wbuf[i] = {$urandom, $urandom};
        wa = 28'h0ABC0C0;
        do_write(wa, 3);
        do_read(wa);

        read_hold(28'h40, wa);
        reset_mid_read(28'h40);

        wr_gap_max = 2;
        for (int n = 0; n < 30; n++) begin
            rd_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < int'(BB); i++) wbuf[i] = {$urandom, $urandom};
                a = AW'($urandom);
                do_write(a, $urandom_range(0, 2));
            end else begin
                k = $urandom_range(0, int'(NBLK) - 1);
                while (!known[k]) k = (k + 1) % int'(NBLK);
                a = AW'(($urandom_range(0, 2047) * NBLK + k) * BLOCK_BYTES
                        + $urandom_range(0, BLOCK_BYTES - 1));
                do_read(a);
            end
        end
        rd_mode = 0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
